// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit.
// Multiplies by radix-2 shift-add and divides by restoring division, both on
// operand magnitudes, one bit per cycle. The sign is fixed up on completion.
// Divide-by-zero and signed overflow finish one cycle after accept.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   req_valid_i      requester offers an operation
//   req_ready_o      unit accepts an operation this cycle (IDLE, no flush/reset)
//   funct3_i         RV32M funct3 (MUL..REMU)
//   op_a_i, op_b_i   rs1 / rs2 values, latched at accept
//   flush_i          abandon any in-flight operation
//   rsp_valid_o      result available (DONE state)
//   rsp_ready_i      consumer takes the result
//   result_o         result, valid while rsp_valid_o
//   busy_o           unit is not in IDLE
module muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int unsigned CNT_W = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q,   state_n;
    logic [CNT_W-1:0] cnt_q,     cnt_n;
    logic [2:0]       f3_q,      f3_n;
    logic [XLEN-1:0]  opnd_q,    opnd_n;
    logic [XLEN-1:0]  hi_q,      hi_n;
    logic [XLEN-1:0]  lo_q,      lo_n;
    logic             neg_quo_q, neg_quo_n;
    logic             neg_rem_q, neg_rem_n;
    logic [XLEN-1:0]  result_q,  result_n;

    logic             accept;
    logic             a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]  mag_a, mag_b;
    logic             b_zero, sgn_ovf;
    logic [XLEN:0]    mul_sum;
    logic [XLEN-1:0]  mul_hi_n, mul_lo_n;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN:0]    div_sh;
    logic             div_ge;
    logic [XLEN-1:0]  div_sub, div_hi_n, div_lo_n;
    logic [XLEN-1:0]  quo_fix, rem_fix;

    assign req_ready_o = (state_q == S_IDLE) && !flush_i && !rst;
    assign rsp_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign result_o    = result_q;
    assign accept      = req_valid_i && req_ready_o;

    // Operand signedness: MULH both, MULHSU rs1 only, DIV/REM both.
    assign a_signed = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                      (funct3_i[2] && !funct3_i[0]);
    assign b_signed = (funct3_i == 3'b001) || (funct3_i[2] && !funct3_i[0]);
    assign a_neg    = a_signed && op_a_i[XLEN-1];
    assign b_neg    = b_signed && op_b_i[XLEN-1];
    assign mag_a    = a_neg ? (~op_a_i + XLEN'(1)) : op_a_i;
    assign mag_b    = b_neg ? (~op_b_i + XLEN'(1)) : op_b_i;
    assign b_zero   = (op_b_i == '0);
    assign sgn_ovf  = !funct3_i[0] && (op_b_i == '1) &&
                      (op_a_i == {1'b1, {(XLEN-1){1'b0}}});

    // One shift-add step: {hi,lo} holds partial product over the shifting multiplier.
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi_n = mul_sum[XLEN:1];
    assign mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    assign prod     = {mul_hi_n, mul_lo_n};
    assign prod_fix = neg_quo_q ? (~prod + (2*XLEN)'(1)) : prod;

    // One restoring step: hi is the partial remainder, lo shifts dividend out / quotient in.
    assign div_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_ge   = (div_sh >= {1'b0, opnd_q});
    assign div_sub  = XLEN'(div_sh - {1'b0, opnd_q});
    assign div_hi_n = div_ge ? div_sub : div_sh[XLEN-1:0];
    assign div_lo_n = {lo_q[XLEN-2:0], div_ge};
    assign quo_fix  = neg_quo_q ? (~div_lo_n + XLEN'(1)) : div_lo_n;
    assign rem_fix  = neg_rem_q ? (~div_hi_n + XLEN'(1)) : div_hi_n;

    // Next-state and datapath update.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        f3_n      = f3_q;
        opnd_n    = opnd_q;
        hi_n      = hi_q;
        lo_n      = lo_q;
        neg_quo_n = neg_quo_q;
        neg_rem_n = neg_rem_q;
        result_n  = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_n     = CNT_W'(XLEN - 1);
                    f3_n      = funct3_i;
                    neg_quo_n = a_neg ^ b_neg;
                    neg_rem_n = a_neg;
                    hi_n      = '0;
                    if (funct3_i[2]) begin
                        opnd_n = mag_b;
                        lo_n   = mag_a;
                        if (b_zero) begin
                            result_n = funct3_i[1] ? op_a_i : '1;
                            state_n  = S_DONE;
                        end else if (sgn_ovf) begin
                            result_n = funct3_i[1] ? '0 : op_a_i;
                            state_n  = S_DONE;
                        end else begin
                            state_n  = S_DIV;
                        end
                    end else begin
                        opnd_n  = mag_a;
                        lo_n    = mag_b;
                        state_n = S_MUL;
                    end
                end
            end
            S_MUL: begin
                hi_n = mul_hi_n;
                lo_n = mul_lo_n;
                if (cnt_q == '0) begin
                    result_n = (f3_q == 3'b000) ? prod_fix[XLEN-1:0]
                                                : prod_fix[2*XLEN-1:XLEN];
                    state_n  = S_DONE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_DIV: begin
                hi_n = div_hi_n;
                lo_n = div_lo_n;
                if (cnt_q == '0) begin
                    result_n = f3_q[1] ? rem_fix : quo_fix;
                    state_n  = S_DONE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                if (rsp_ready_i) begin
                    state_n = S_IDLE;
                end
            end
        endcase

        // Flush beats completion and the response handshake.
        if (flush_i) begin
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            f3_q      <= f3_n;
            opnd_q    <= opnd_n;
            hi_q      <= hi_n;
            lo_q      <= lo_n;
            neg_quo_q <= neg_quo_n;
            neg_rem_q <= neg_rem_n;
            result_q  <= result_n;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table plus
// backpressure, flush and reset sequences.
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        flush_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .funct3_i    (funct3_i),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .flush_i     (flush_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .result_o    (result_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle; it is accepted at the next edge.
    task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b);
        req_valid_i = 1'b1;
        funct3_i    = f3;
        op_a_i      = a;
        op_b_i      = b;
        check({name, " req_ready"}, 32'(req_ready_o), 32'd1);
        step();
        req_valid_i = 1'b0;
        op_a_i      = $urandom;
        op_b_i      = $urandom;
        funct3_i    = 3'($urandom);
    endtask

    // Cycles after accept until rsp_valid_o; 40 means it never came.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid_o && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic fill_vecs();
        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[7]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
        vecs[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[9]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[10] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33};
        vecs[11] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[12] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[13] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[14] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[15] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[16] = '{3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33};
        vecs[17] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1};
        vecs[18] = '{3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 33};
        vecs[19] = '{3'b010, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    endtask

    initial begin
        int    lat;
        string nm;
        logic [31:0] held;

        rst         = 1'b1;
        req_valid_i = 1'b0;
        funct3_i    = '0;
        op_a_i      = '0;
        op_b_i      = '0;
        flush_i     = 1'b0;
        rsp_ready_i = 1'b1;
        fill_vecs();

        // Reset state, sampled while rst is still asserted.
        step();
        step();
        check("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst result",    result_o,         32'd0);
        check("rst busy",      32'(busy_o),      32'd0);
        check("rst req_ready", 32'(req_ready_o), 32'd0);
        rst = 1'b0;
        #1;
        check("post-rst req_ready", 32'(req_ready_o), 32'd1);

        // Directed vectors, consumed immediately.
        for (int i = 0; i < NVEC; i++) begin
            nm = $sformatf("vec%0d", i);
            issue(nm, vecs[i].f3, vecs[i].a, vecs[i].b);
            wait_rsp(lat);
            check({nm, " latency"},   32'(lat),         32'(vecs[i].lat));
            check({nm, " result"},    result_o,         vecs[i].exp);
            check({nm, " ready@done"}, 32'(req_ready_o), 32'd0);
            step();
            check({nm, " rsp_valid after"}, 32'(rsp_valid_o), 32'd0);
            check({nm, " idle ready"},      32'(req_ready_o), 32'd1);
        end

        // Backpressure: response held for 5 cycles with result stable.
        rsp_ready_i = 1'b0;
        issue("bp", 3'b000, 32'd3, 32'd5);
        wait_rsp(lat);
        check("bp latency", 32'(lat), 32'd33);
        held = result_o;
        check("bp result", held, 32'd15);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("bp hold%0d valid", k),  32'(rsp_valid_o), 32'd1);
            check($sformatf("bp hold%0d result", k), result_o,         32'd15);
            check($sformatf("bp hold%0d ready", k),  32'(req_ready_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        step();
        check("bp release valid", 32'(rsp_valid_o), 32'd0);
        check("bp release ready", 32'(req_ready_o), 32'd1);
        check("bp release busy",  32'(busy_o),      32'd0);

        // Flush at T+10 of a divide: no response, IDLE once flush drops.
        issue("fl", 3'b100, 32'd1000, 32'd7);
        for (int k = 1; k < 10; k++) step();
        flush_i = 1'b1;
        #1;
        check("fl ready during flush", 32'(req_ready_o), 32'd0);
        step();
        flush_i = 1'b0;
        #1;
        check("fl busy",      32'(busy_o),      32'd0);
        check("fl ready",     32'(req_ready_o), 32'd1);
        check("fl rsp_valid", 32'(rsp_valid_o), 32'd0);

        // Reset at T+5 of a multiply: no response.
        issue("rs", 3'b000, 32'd9, 32'd9);
        for (int k = 1; k < 5; k++) step();
        rst = 1'b1;
        #1;
        check("rs ready during rst", 32'(req_ready_o), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("rs busy",      32'(busy_o),      32'd0);
        check("rs ready",     32'(req_ready_o), 32'd1);
        check("rs rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rs result",    result_o,         32'd0);

        // Neither aborted operation produces a late response.
        for (int k = 0; k < 40; k++) begin
            step();
            if (rsp_valid_o) break;
        end
        check("no late rsp", 32'(rsp_valid_o), 32'd0);

        // Flush wins over a response handshake in DONE.
        rsp_ready_i = 1'b0;
        issue("fd", 3'b101, 32'd5, 32'd0);
        wait_rsp(lat);
        check("fd latency", 32'(lat), 32'd1);
        flush_i     = 1'b1;
        rsp_ready_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        check("fd rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("fd ready",     32'(req_ready_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid_i  input  1  requester offers an RV32M operation.
REQ-005 SHALL have port req_ready_o  output  1  unit accepts an operation this cycle.
REQ-006 SHALL have port funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port op_a_i  input  XLEN  rs1 value.
REQ-008 SHALL have port op_b_i  input  XLEN  rs2 value.
REQ-009 SHALL have port flush_i  input  1  abandon any in-flight operation.
REQ-010 SHALL have port rsp_valid_o  output  1  result available.
REQ-011 SHALL have port rsp_ready_i  input  1  consumer takes result.
REQ-012 SHALL have port result_o  output  XLEN  result; valid only while rsp_valid_o=1.
REQ-013 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-015 SHALL assert req_ready_o only in IDLE with flush_i=0.
REQ-016 SHALL accept on req_valid_i && req_ready_o (cycle T); SHALL latch funct3_i, op_a_i, op_b_i at T.
REQ-017 SHALL ignore operand changes after T.
REQ-018 Multiply: radix-2 shift-add on operand magnitudes, one bit per cycle, 32 cycles in MUL (T+1..T+32); sign fixup per funct3 (MULH both signed, MULHSU a signed/b unsigned, MULHU none).
REQ-019 MUL SHALL return low 32 bits of the 64-bit product; MULH/MULHSU/MULHU SHALL return the high 32 bits.
REQ-020 Divide: restoring division on magnitudes, 32 cycles in DIV; quotient sign = sign(a) xor sign(b); remainder sign = sign(a) for DIV/REM.
REQ-021 Normal completion SHALL enter DONE at T+33 with rsp_valid_o=1.
REQ-022 Divide by zero (op_b=0) SHALL bypass DIV and enter DONE at T+1: DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> op_a.
REQ-023 Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF) SHALL enter DONE at T+1: DIV -> 0x80000000, REM -> 0.
REQ-024 In DONE, rsp_valid_o SHALL stay high and result_o stable until rsp_valid_o && rsp_ready_i; next cycle -> IDLE.
REQ-025 No new request SHALL be accepted in the cycle the response is consumed (min issue interval = latency + 1).
REQ-026 flush_i=1 in any state SHALL force IDLE next cycle, drop the result, and produce no rsp_valid_o; flush_i has priority over completion and over a response handshake in the same cycle.
REQ-027 Iteration counter SHALL be 6 bits, loaded with 31 at accept, decrement each MUL/DIV cycle, exit on 0 (no wrap).

Reset
REQ-028 With rst=1 at a rising edge: state=IDLE, counter=0, rsp_valid_o=0, result_o=0, busy_o=0; req_ready_o=0 while rst=1.
REQ-029 Reset mid-operation SHALL discard the operation with no response; rst has priority over flush_i and all handshakes.

Verification
REQ-030 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, rsp_valid_o at T+33.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; both at T+33.
REQ-033 DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5 at T+1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1.
REQ-034 Hold rsp_ready_i=0 for 5 cycles after DONE -> result_o stable, req_ready_o=0; then release -> IDLE the next cycle.
REQ-035 Assert flush_i at T+10, then rst at T+5 of a second operation -> no rsp_valid_o for either; IDLE with req_ready_o=1 the cycle after each is deasserted.
